// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DBG memory arbiter: parameter defaults,
// the access-owner encoding and a small owner-selection helper.
package mem_arbiter_pkg;

  localparam int AW_DEF           = 32;
  localparam int DW_DEF           = 32;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int SCW_DEF          = 16;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  function automatic owner_e owner_of(input logic dbg_gnt);
    owner_of = dbg_gnt ? OWN_DBG : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Parameterised saturating up-counter with synchronous clear; clear has
// priority over increment and the count holds once it reaches MAX.
module sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register: async reset, clear, saturating increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1'b1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority CPU/DBG arbiter for the shared single-port memory, with a
// starvation counter that forces one DBG slot after STARVE_LIMIT waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int SCW          = SCW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_adr,
  input  logic [DW-1:0] dbg_wd,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [SCW-1:0] stall_count
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_r;
  logic          force_s;
  logic          dbg_gnt_s;
  owner_e        owner_s;

  assign force_s   = (starve_cnt_r == STARVE_MAX);
  assign dbg_gnt_s = ~reset & dbg_req & (~cpu_req | force_s);
  assign owner_s   = owner_of(dbg_gnt_s);

  assign dbg_gnt   = dbg_gnt_s;
  assign cpu_stall = cpu_req & dbg_gnt_s;
  assign cpu_rd    = mem_rd;

  // Memory port mux; writes are suppressed while reset is held.
  always_comb begin
    mem_a  = cpu_adr;
    mem_wd = cpu_wd;
    mem_we = 1'b0;
    case (owner_s)
      OWN_DBG: begin
        mem_a  = dbg_adr;
        mem_wd = dbg_wd;
        mem_we = dbg_we;
      end
      OWN_CPU: begin
        mem_a  = cpu_adr;
        mem_wd = cpu_wd;
        mem_we = cpu_we & cpu_req & ~reset;
      end
      default: begin
        mem_a  = cpu_adr;
        mem_wd = cpu_wd;
        mem_we = 1'b0;
      end
    endcase
  end

  // Waiting cycles of a pending DBG request; a grant or idle DBG restarts it.
  sat_counter #(
    .W   (SW),
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (dbg_gnt_s | ~dbg_req),
    .inc   (1'b1),
    .cnt   (starve_cnt_r)
  );

  sat_counter #(
    .W   (SCW),
    .MAX ({SCW{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (cpu_stall),
    .cnt   (stall_count)
  );

  // Registered DBG read response: one-cycle valid pulse, data held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= {DW{1'b0}};
    end else if (dbg_gnt_s && !dbg_we) begin
      dbg_rvalid <= 1'b1;
      dbg_rdata  <= mem_rd;
    end else begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= dbg_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 8;
  localparam int SCW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_adr, dbg_adr;
  logic [DW-1:0] cpu_wd, dbg_wd;
  logic [DW-1:0] cpu_rd, dbg_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;
  logic          cpu_stall, dbg_gnt, dbg_rvalid, mem_we;
  logic [SCW-1:0] stall_count;

  logic [DW-1:0] mem [0:255];

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .SCW(SCW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h44; cpu_wd = 32'h11111111;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h10; dbg_wd = 32'h0;
    #1;
    // reset state
    chk("rst_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'h44);
    chk("rst_mem_wd", mem_wd, 32'h11111111);
    step(); step();
    chk("rst_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_stall_count", {28'b0, stall_count}, 32'd0);
    chk("rst_mem44_unwritten", mem[8'h44], 32'h0);

    // DBG-only read
    cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h10;
    reset = 1'b0;
    #1;
    chk("dbgonly_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbgonly_stall", {31'b0, cpu_stall}, 32'd0);
    chk("dbgonly_mem_a", mem_a, 32'h10);
    step();
    dbg_req = 1'b0;
    chk("dbgonly_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    chk("dbgonly_rdata", dbg_rdata, 32'hDEADBEEF);
    step();
    chk("dbgonly_rvalid_pulse", {31'b0, dbg_rvalid}, 32'd0);
    chk("dbgonly_rdata_hold", dbg_rdata, 32'hDEADBEEF);

    // CPU pass-through read and write
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
    #1;
    chk("cpu_rd", cpu_rd, 32'hDEADBEEF);
    cpu_we = 1'b1; cpu_adr = 32'h30; cpu_wd = 32'hA5A5A5A5;
    step();
    cpu_we = 1'b0;
    chk("cpu_write", mem[8'h30], 32'hA5A5A5A5);

    // contention: forced grants at cycles 8 and 17 only
    cpu_req = 1'b1; cpu_adr = 32'h30; dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h10;
    for (int c = 0; c < 18; c++) begin
      #1;
      chk($sformatf("cont_gnt_c%0d", c), {31'b0, dbg_gnt}, {31'b0, (c == 8 || c == 17)});
      chk($sformatf("cont_stall_c%0d", c), {31'b0, cpu_stall}, {31'b0, (c == 8 || c == 17)});
      step();
      if (c == 8) begin
        chk("cont_stall_count1", {28'b0, stall_count}, 32'd1);
        chk("cont_rvalid", {31'b0, dbg_rvalid}, 32'd1);
      end
    end
    dbg_req = 1'b0;
    chk("cont_stall_count2", {28'b0, stall_count}, 32'd2);

    // DBG write under force; CPU write in the forced cycle is dropped
    cpu_we = 1'b1; cpu_adr = 32'h24; cpu_wd = 32'hBAD0BAD0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h20; dbg_wd = 32'h12345678;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) cpu_wd = 32'hCAFEF00D;
      #1;
      chk($sformatf("wr_gnt_c%0d", c), {31'b0, dbg_gnt}, {31'b0, (c == 8)});
      step();
    end
    cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    chk("wr_dbg_mem", mem[8'h20], 32'h12345678);
    chk("wr_cpu_kept", mem[8'h24], 32'hBAD0BAD0);
    chk("wr_no_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("wr_stall_count", {28'b0, stall_count}, 32'd3);

    // reset mid-contention: counter restarts from 0
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_adr = 32'h10;
    for (int c = 0; c < 4; c++) step();
    reset = 1'b1; cpu_we = 1'b1;
    #1;
    chk("mid_rst_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("mid_rst_stall_count", {28'b0, stall_count}, 32'd0);
    step();
    cpu_we = 1'b0; reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("restart_gnt_c%0d", c), {31'b0, dbg_gnt}, {31'b0, (c == 8)});
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("restart_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    // pending read response dropped by reset
    reset = 1'b1;
    #1;
    chk("drop_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("drop_rdata", dbg_rdata, 32'd0);
    chk("drop_stall_count", {28'b0, stall_count}, 32'd0);
    step();
    reset = 1'b0;

    // saturation: 20 forced stalls into a 4-bit counter
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int c = 0; c < 20 * 9; c++) step();
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("sat_stall_count", {28'b0, stall_count}, 32'd15);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port unified `mem` between the multicycle ARM core (CPU port) and a debug/display master (DBG port, used for memory dumps to the hex display). It sits between the core and `mem` in the top level. The CPU has fixed priority. A starvation counter forces a DBG slot after `STARVE_LIMIT` waiting cycles, and stalls the CPU for exactly that cycle. CPU reads stay combinational pass-through; DBG reads return through a registered response.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_LIMIT`, 8, DBG waiting cycles before a forced grant (≥1)
- `SCW`, 16, stall-counter width

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `cpu_req` in 1: CPU wants memory this cycle
- `cpu_we` in 1: CPU write
- `cpu_adr` in AW: CPU address
- `cpu_wd` in DW: CPU write data
- `cpu_rd` out DW: CPU read data
- `cpu_stall` out 1: CPU must hold its state and request
- `dbg_req` in 1: DBG request (held until granted)
- `dbg_we` in 1: DBG write
- `dbg_adr` in AW: DBG address
- `dbg_wd` in DW: DBG write data
- `dbg_gnt` out 1: DBG access performed this cycle
- `dbg_rvalid` out 1: DBG read data valid (1-cycle pulse)
- `dbg_rdata` out DW: DBG read data
- `mem_we` out 1: to `mem.we`
- `mem_a` out AW: to `mem.a`
- `mem_wd` out DW: to `mem.wd`
- `mem_rd` in DW: from `mem.rd` (combinational read)
- `stall_count` out SCW: saturating count of CPU stall cycles

## Operation
- `force = (starve_cnt == STARVE_LIMIT)`
- `dbg_gnt = !reset & dbg_req & (!cpu_req | force)`. This is combinational and decided within the cycle.
- `cpu_stall = cpu_req & dbg_gnt`
- Memory mux:
  - When `dbg_gnt` is high, `mem_a`, `mem_wd` and `mem_we` come from the DBG side.
  - Otherwise they come from the CPU side, with `mem_we = cpu_we & cpu_req`.
  - `mem_we` is 0 while `reset` is high.
- `cpu_rd = mem_rd` always. The CPU ignores it when stalled.
- `starve_cnt` (width clog2(STARVE_LIMIT+1)):
  - Clears to 0 when `dbg_gnt` is high or `dbg_req` is low.
  - Otherwise increments, saturating at `STARVE_LIMIT`.
- After a forced grant the counter is 0, so the CPU keeps priority for at least `STARVE_LIMIT` cycles. No back-to-back forced grants.
- DBG read: on a cycle with `dbg_gnt & !dbg_we`, `dbg_rdata <= mem_rd` and `dbg_rvalid <= 1` at the next edge. Otherwise `dbg_rvalid <= 0` and `dbg_rdata` holds.
- DBG write: completes at the granted edge. No `rvalid` pulse.
- `stall_count` increments on every cycle with `cpu_stall` high and saturates at all-ones.
- Simultaneous requests without `force`: CPU wins, DBG waits, counter advances.
- Reset mid-operation:
  - Counter, `dbg_rvalid`, `dbg_rdata` and `stall_count` clear immediately.
  - `dbg_gnt`, `cpu_stall` and `mem_we` go low.
  - A pending DBG read response is dropped.

## Timing
- Reset values:
  - `dbg_rvalid` = 0, `dbg_rdata` = 0, `stall_count` = 0
  - `dbg_gnt` = 0, `cpu_stall` = 0, `mem_we` = 0
  - `mem_a`, `mem_wd` and `cpu_rd` follow the CPU side.
- CPU access latency: 0 extra cycles when not stalled.
- DBG read latency: `dbg_rvalid` is high 1 cycle after `dbg_gnt`.
- Worst-case DBG wait with `cpu_req` held high: grant in cycle `STARVE_LIMIT`, counting from 0 as the first request cycle.
- A stalled CPU is delayed exactly 1 cycle per forced grant.

## Structure
- A shared defs file holds the defaults for `AW`, `DW`, `STARVE_LIMIT` and `SCW`, and the owner encoding `OWN_CPU` = 0, `OWN_DBG` = 1.
- One sub-module is natural: `sat_counter`, a parameterised-width saturating counter with clear, used for both `starve_cnt` and `stall_count`.

## Test plan
- DBG-only traffic:
  - Stimulus: `dbg_req=1`, `dbg_we=0`, `dbg_adr=0x10`, `cpu_req=0`, mem[0x10]=0xDEADBEEF.
  - Response: `dbg_gnt=1` the same cycle; next cycle `dbg_rvalid=1` and `dbg_rdata=0xDEADBEEF`; `cpu_stall=0`.
- Contention without force:
  - Stimulus: `cpu_req=1` and `dbg_req=1` from cycle 0, `STARVE_LIMIT=8`.
  - Response: `dbg_gnt=0` for cycles 0–7; `dbg_gnt=1` and `cpu_stall=1` in cycle 8 only; `stall_count=1`.
- DBG write under force:
  - Stimulus: DBG writes 0x12345678 to 0x20 while `cpu_req` is held.
  - Response: mem[0x20]=0x12345678 after the forced grant; no `dbg_rvalid` pulse; the CPU write in the same cycle is not performed.
- No back-to-back forced grants:
  - Stimulus: `dbg_req` held continuously with `cpu_req` held.
  - Response: grants spaced exactly 9 cycles apart.
- Reset mid-operation:
  - Stimulus: assert `reset` in the cycle after a DBG read grant.
  - Response: `dbg_rvalid` stays 0; `stall_count` = 0; counter restarts from 0 after release.
- Saturation:
  - Stimulus: `SCW=4`, force 20 stalls.
  - Response: `stall_count` holds at 15.
